// File: rtl/ghosts_path_engine.sv
// ghosts_path_engine: steps NUM_GHOSTS ghosts toward pacman by picking the cheapest in-range neighbour in the proximity map.
// Optional feature macro GHOST_NO_REVERSE_EN: a ghost may not step back onto its previous cell except to escape a dead end.
module ghosts_path_engine #(
    parameter int NUM_GHOSTS = 4,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int VAL_W      = 8,
    parameter int WALL_VAL   = 255,
    parameter int DELAY      = 30000000,
    parameter int HOME_X     = 16,
    parameter int HOME_DX    = 7,
    parameter int HOME_Y     = 13
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        map_ready,
    input  logic                        wrdone,
    input  logic [X_W-1:0]              pacman_x,
    input  logic [Y_W-1:0]              pacman_y,
    output logic [X_W-1:0]              rdaddr_x,
    output logic [Y_W-1:0]              rdaddr_y,
    input  logic [VAL_W-1:0]            rd_data,
    output logic [NUM_GHOSTS*X_W-1:0]   curr_x,
    output logic [NUM_GHOSTS*Y_W-1:0]   curr_y,
    output logic [NUM_GHOSTS*X_W-1:0]   prev_x,
    output logic [NUM_GHOSTS*Y_W-1:0]   prev_y,
    output logic [NUM_GHOSTS*X_W-1:0]   next_x,
    output logic [NUM_GHOSTS*Y_W-1:0]   next_y,
    output logic                        scan_done,
    output logic                        busy,
    output logic                        hit
);
    localparam int G_W   = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int CNT_W = $clog2(DELAY + 1);
    localparam logic [VAL_W-1:0] WALL_V   = VAL_W'(WALL_VAL);
    localparam logic [G_W-1:0]   LAST_G   = G_W'(NUM_GHOSTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, COMMIT, WAIT} state_t;

    state_t state_q, state_d;
    logic [G_W-1:0] g_q, g_d;
    logic [1:0] d_q, d_d;
    logic [X_W-1:0] addr_x_q, addr_x_d, cand_x;
    logic [Y_W-1:0] addr_y_q, addr_y_d, cand_y;
    logic cand_ok, cand_rev, cand_ok_q, cand_ok_d, cand_rev_q, cand_rev_d, take;
    logic [NUM_GHOSTS-1:0][X_W-1:0] curr_x_q, curr_x_d, prev_x_q, prev_x_d;
    logic [NUM_GHOSTS-1:0][X_W-1:0] next_x_q, next_x_d, min_x_q, min_x_d;
    logic [NUM_GHOSTS-1:0][Y_W-1:0] curr_y_q, curr_y_d, prev_y_q, prev_y_d;
    logic [NUM_GHOSTS-1:0][Y_W-1:0] next_y_q, next_y_d, min_y_q, min_y_d;
    logic [NUM_GHOSTS-1:0][VAL_W-1:0] min_val_q, min_val_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic hit_q, hit_d;
`ifdef GHOST_NO_REVERSE_EN
    logic [VAL_W-1:0] rev_val_q, rev_val_d;
    logic rev_seen_q, rev_seen_d, other_ok_q, other_ok_d;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && map_ready) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = (d_q == 2'd3 && g_q == LAST_G) ? COMMIT : ISSUE;
            COMMIT:  state_d = WAIT;
            WAIT:    if (cnt_q == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ISSUE) || (state_q == CAPTURE);
        scan_done = (state_q == COMMIT);
        rdaddr_x  = (state_q == ISSUE) ? cand_x : addr_x_q;
        rdaddr_y  = (state_q == ISSUE) ? cand_y : addr_y_q;
    end

    // Neighbour address wraps naturally; cand_ok flags the grid-edge cases that must be skipped.
    always_comb begin
        cand_x  = curr_x_q[g_q];
        cand_y  = curr_y_q[g_q];
        cand_ok = 1'b1;
        case (d_q)
            2'd0: begin cand_y = curr_y_q[g_q] - Y_W'(1); cand_ok = (curr_y_q[g_q] != '0); end
            2'd1: begin cand_y = curr_y_q[g_q] + Y_W'(1); cand_ok = (curr_y_q[g_q] != '1); end
            2'd2: begin cand_x = curr_x_q[g_q] - X_W'(1); cand_ok = (curr_x_q[g_q] != '0); end
            default: begin cand_x = curr_x_q[g_q] + X_W'(1); cand_ok = (curr_x_q[g_q] != '1); end
        endcase
`ifdef GHOST_NO_REVERSE_EN
        cand_rev = (cand_x == prev_x_q[g_q]) && (cand_y == prev_y_q[g_q]);
`else
        cand_rev = 1'b0;
`endif
    end

    always_comb begin
        g_d        = g_q;
        d_d        = d_q;
        addr_x_d   = addr_x_q;
        addr_y_d   = addr_y_q;
        cand_ok_d  = cand_ok_q;
        cand_rev_d = cand_rev_q;
        min_x_d    = min_x_q;
        min_y_d    = min_y_q;
        min_val_d  = min_val_q;
        curr_x_d   = curr_x_q;
        curr_y_d   = curr_y_q;
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        next_x_d   = next_x_q;
        next_y_d   = next_y_q;
        cnt_d      = '0;
        take       = 1'b0;
`ifdef GHOST_NO_REVERSE_EN
        rev_val_d  = rev_val_q;
        rev_seen_d = rev_seen_q;
        other_ok_d = other_ok_q;
`endif
        case (state_q)
            IDLE: begin
                if (state_d == ISSUE) begin
                    g_d = '0;
                    d_d = '0;
                    for (int g = 0; g < NUM_GHOSTS; g++) begin
                        min_x_d[g]   = curr_x_q[g];
                        min_y_d[g]   = curr_y_q[g];
                        min_val_d[g] = WALL_V;
                    end
                end
            end
            ISSUE: begin
                addr_x_d   = cand_x;
                addr_y_d   = cand_y;
                cand_ok_d  = cand_ok;
                cand_rev_d = cand_rev;
            end
            CAPTURE: begin
                // Strict less-than keeps the earliest direction on ties.
                take = cand_ok_q && !cand_rev_q && (rd_data < min_val_q[g_q]) && (rd_data < WALL_V);
                if (take) begin
                    min_x_d[g_q]   = addr_x_q;
                    min_y_d[g_q]   = addr_y_q;
                    min_val_d[g_q] = rd_data;
                end
`ifdef GHOST_NO_REVERSE_EN
                rev_seen_d = (d_q == 2'd0) ? 1'b0 : rev_seen_q;
                other_ok_d = (d_q == 2'd0) ? 1'b0 : other_ok_q;
                if (cand_ok_q && cand_rev_q) begin
                    rev_seen_d = 1'b1;
                    rev_val_d  = rd_data;
                end else if (cand_ok_q && (rd_data < WALL_V)) begin
                    other_ok_d = 1'b1;
                end
                // Dead end: every other way is blocked, so the reverse cell is allowed after all.
                if (d_q == 2'd3 && rev_seen_d && !other_ok_d && (rev_val_d < WALL_V)) begin
                    min_x_d[g_q]   = prev_x_q[g_q];
                    min_y_d[g_q]   = prev_y_q[g_q];
                    min_val_d[g_q] = rev_val_d;
                end
`endif
                d_d = d_q + 2'd1;
                if (d_q == 2'd3) g_d = (g_q == LAST_G) ? '0 : g_q + G_W'(1);
            end
            COMMIT: begin
                next_x_d = min_x_q;
                next_y_d = min_y_q;
            end
            WAIT: cnt_d = cnt_q + CNT_W'(1);
            default: ;
        endcase
        if (wrdone) begin
            prev_x_d = curr_x_q;
            prev_y_d = curr_y_q;
            curr_x_d = next_x_q;
            curr_y_d = next_y_q;
        end
        hit_d = 1'b0;
        for (int g = 0; g < NUM_GHOSTS; g++)
            if (curr_x_q[g] == pacman_x && curr_y_q[g] == pacman_y) hit_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            g_q        <= '0;
            d_q        <= '0;
            addr_x_q   <= X_W'(HOME_X);
            addr_y_q   <= Y_W'(HOME_Y);
            cand_ok_q  <= 1'b0;
            cand_rev_q <= 1'b0;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            for (int g = 0; g < NUM_GHOSTS; g++) begin
                curr_x_q[g]  <= X_W'(HOME_X + g * HOME_DX);
                prev_x_q[g]  <= X_W'(HOME_X + g * HOME_DX);
                next_x_q[g]  <= X_W'(HOME_X + g * HOME_DX);
                min_x_q[g]   <= X_W'(HOME_X + g * HOME_DX);
                curr_y_q[g]  <= Y_W'(HOME_Y);
                prev_y_q[g]  <= Y_W'(HOME_Y);
                next_y_q[g]  <= Y_W'(HOME_Y);
                min_y_q[g]   <= Y_W'(HOME_Y);
                min_val_q[g] <= WALL_V;
            end
`ifdef GHOST_NO_REVERSE_EN
            rev_val_q  <= WALL_V;
            rev_seen_q <= 1'b0;
            other_ok_q <= 1'b0;
`endif
        end else begin
            g_q        <= g_d;
            d_q        <= d_d;
            addr_x_q   <= addr_x_d;
            addr_y_q   <= addr_y_d;
            cand_ok_q  <= cand_ok_d;
            cand_rev_q <= cand_rev_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            curr_x_q   <= curr_x_d;
            curr_y_q   <= curr_y_d;
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
            next_x_q   <= next_x_d;
            next_y_q   <= next_y_d;
            min_x_q    <= min_x_d;
            min_y_q    <= min_y_d;
            min_val_q  <= min_val_d;
`ifdef GHOST_NO_REVERSE_EN
            rev_val_q  <= rev_val_d;
            rev_seen_q <= rev_seen_d;
            other_ok_q <= other_ok_d;
`endif
        end
    end

    assign curr_x = curr_x_q;
    assign curr_y = curr_y_q;
    assign prev_x = prev_x_q;
    assign prev_y = prev_y_q;
    assign next_x = next_x_q;
    assign next_y = next_y_q;
    assign hit    = hit_q;
endmodule

// File: tb/tb_ghosts_path_engine.sv
// Directed bench for ghosts_path_engine with two ghosts and a short step delay.
// Honours GHOST_NO_REVERSE_EN for the reverse-move expectations.
module tb_ghosts_path_engine;
    localparam int NG = 2;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int VW = 8;

    logic CLOCK_50 = 1'b0;
    logic reset_n, enable, map_ready, wrdone;
    logic [XW-1:0] pacman_x, rdaddr_x;
    logic [YW-1:0] pacman_y, rdaddr_y;
    logic [VW-1:0] rd_data;
    logic [NG*XW-1:0] curr_x, prev_x, next_x;
    logic [NG*YW-1:0] curr_y, prev_y, next_y;
    logic scan_done, busy, hit;
    logic [VW-1:0] mem [64][32];
    int compared = 0;
    int mismatched = 0;
    int cyc;
    int revY;

    ghosts_path_engine #(.NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .VAL_W(VW), .WALL_VAL(255),
                         .DELAY(4), .HOME_X(16), .HOME_DX(7), .HOME_Y(13)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable), .map_ready(map_ready),
        .wrdone(wrdone), .pacman_x(pacman_x), .pacman_y(pacman_y),
        .rdaddr_x(rdaddr_x), .rdaddr_y(rdaddr_y), .rd_data(rd_data),
        .curr_x(curr_x), .curr_y(curr_y), .prev_x(prev_x), .prev_y(prev_y),
        .next_x(next_x), .next_y(next_y), .scan_done(scan_done), .busy(busy), .hit(hit));

    // 50 MHz-style free-running clock
    always #10 CLOCK_50 = ~CLOCK_50;

    // Proximity RAM model with one cycle of read latency
    always @(posedge CLOCK_50) rd_data <= mem[rdaddr_x][rdaddr_y];

    // Pack two ghost coordinates the way the DUT outputs them (ghost 0 in the low bits)
    function automatic logic [NG*XW-1:0] px(input int a, input int b);
        return {XW'(b), XW'(a)};
    endfunction

    function automatic logic [NG*YW-1:0] py(input int a, input int b);
        return {YW'(b), YW'(a)};
    endfunction

    // One comparison: counts it, and on disagreement counts and reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the control inputs for one cycle; wrdone is a single-cycle pulse
    task automatic applyStimulus(input logic en, input logic mr, input logic wd);
        enable = en;
        map_ready = mr;
        wrdone = wd;
        @(negedge CLOCK_50);
        wrdone = 1'b0;
    endtask

    task automatic fillMap(input logic [VW-1:0] v);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                mem[x][y] = v;
    endtask

    // Cost rises with x so every ghost prefers stepping left
    task automatic fillRamp();
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                mem[x][y] = VW'(100 + x);
    endtask

    task automatic setCell(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [VW-1:0] v);
        mem[x][y] = v;
    endtask

    // Start a round and wait (bounded) for the COMMIT pulse, counting busy cycles on the way.
    // Returns at the COMMIT negedge, or one cycle later when wrdone is fired on the COMMIT cycle.
    task automatic runRound(input bit wdCommit, output int cycles);
        bit seen;
        cycles = 0;
        seen = 1'b0;
        enable = 1'b1;
        map_ready = 1'b1;
        for (int budget = 0; budget < 200; budget++) begin
            @(negedge CLOCK_50);
            if (scan_done) begin
                seen = 1'b1;
                break;
            end
            if (busy) cycles++;
        end
        enable = 1'b0;
        checkOutput("scan_done_seen", 32'(seen), 32'd1);
        if (wdCommit) applyStimulus(1'b0, 1'b1, 1'b1);
    endtask

    // Directed sequence
    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        map_ready = 1'b0;
        wrdone = 1'b0;
        pacman_x = 6'd40;
        pacman_y = 5'd0;
        fillMap(8'd200);
        repeat (2) @(negedge CLOCK_50);

        // Reset state
        checkOutput("rst_curr_x", 32'(curr_x), 32'(px(16, 23)));
        checkOutput("rst_curr_y", 32'(curr_y), 32'(py(13, 13)));
        checkOutput("rst_prev_x", 32'(prev_x), 32'(px(16, 23)));
        checkOutput("rst_prev_y", 32'(prev_y), 32'(py(13, 13)));
        checkOutput("rst_next_x", 32'(next_x), 32'(px(16, 23)));
        checkOutput("rst_next_y", 32'(next_y), 32'(py(13, 13)));
        checkOutput("rst_hit", 32'(hit), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_scan_done", 32'(scan_done), 32'd0);
        checkOutput("rst_rdaddr_x", 32'(rdaddr_x), 32'd16);
        checkOutput("rst_rdaddr_y", 32'(rdaddr_y), 32'd13);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Up 10, down 5, left 5, right 9: down wins the tie with left
        fillMap(8'd200);
        setCell(16, 12, 10); setCell(16, 14, 5); setCell(15, 13, 5); setCell(17, 13, 9);
        setCell(23, 12, 10); setCell(23, 14, 5); setCell(22, 13, 5); setCell(24, 13, 9);
        runRound(1'b0, cyc);
        checkOutput("round_cycles", 32'(cyc), 32'd16);
        checkOutput("commit_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("scan_done_pulse", 32'(scan_done), 32'd0);
        checkOutput("tie_next_x", 32'(next_x), 32'(px(16, 23)));
        checkOutput("tie_next_y", 32'(next_y), 32'(py(14, 14)));
        checkOutput("tie_curr_y_held", 32'(curr_y), 32'(py(13, 13)));

        // wrdone moves the ghosts; hit follows one cycle later
        pacman_x = 6'd23;
        pacman_y = 5'd14;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("wr_curr_y", 32'(curr_y), 32'(py(14, 14)));
        checkOutput("wr_prev_y", 32'(prev_y), 32'(py(13, 13)));
        checkOutput("hit_lag", 32'(hit), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("hit_set", 32'(hit), 32'd1);
        pacman_x = 6'd40;
        pacman_y = 5'd0;

        // All walls: nobody moves
        fillMap(8'd255);
        runRound(1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wall_next_x", 32'(next_x), 32'(px(16, 23)));
        checkOutput("wall_next_y", 32'(next_y), 32'(py(14, 14)));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("wall_curr_x", 32'(curr_x), 32'(px(16, 23)));
        checkOutput("wall_curr_y", 32'(curr_y), 32'(py(14, 14)));

        // Walk both ghosts left 16 times so ghost 0 reaches the x=0 edge
        fillRamp();
        for (int i = 0; i < 16; i++) begin
            runRound(1'b0, cyc);
            applyStimulus(1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("walk_curr_x", 32'(curr_x), 32'(px(0, 7)));
        checkOutput("walk_curr_y", 32'(curr_y), 32'(py(14, 14)));

        // Left of x=0 wraps to x=63 holding 0, which must be skipped
        fillMap(8'd255);
        setCell(63, 14, 0);
        setCell(1, 14, 4);
        runRound(1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("edge_next_x", 32'(next_x), 32'(px(1, 7)));
        checkOutput("edge_next_y", 32'(next_y), 32'(py(14, 14)));

        // wrdone on the COMMIT cycle: curr takes the old next, new next lands as normal
        fillMap(8'd255);
        setCell(0, 15, 3);
        setCell(7, 13, 3);
        runRound(1'b1, cyc);
        checkOutput("cwr_curr_x", 32'(curr_x), 32'(px(1, 7)));
        checkOutput("cwr_curr_y", 32'(curr_y), 32'(py(14, 14)));
        checkOutput("cwr_prev_x", 32'(prev_x), 32'(px(0, 7)));
        checkOutput("cwr_next_x", 32'(next_x), 32'(px(0, 7)));
        checkOutput("cwr_next_y", 32'(next_y), 32'(py(15, 13)));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("cwr2_curr_x", 32'(curr_x), 32'(px(0, 7)));
        checkOutput("cwr2_curr_y", 32'(curr_y), 32'(py(15, 13)));

        // Reset in the middle of a scan aborts it
        for (int i = 0; i < 20 && !busy; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_curr_x", 32'(curr_x), 32'(px(16, 23)));
        checkOutput("abort_next_y", 32'(next_y), 32'(py(13, 13)));
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort_idle", 32'(busy), 32'd0);

        // Build prev=(16,12), curr=(16,13) for ghost 0
        fillMap(8'd255);
        setCell(16, 12, 1);
        runRound(1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("up_next_y", 32'(next_y), 32'(py(12, 13)));
        applyStimulus(1'b0, 1'b1, 1'b1);
        fillMap(8'd255);
        setCell(16, 13, 1);
        runRound(1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("back_next_y", 32'(next_y), 32'(py(13, 13)));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("back_curr_y", 32'(curr_y), 32'(py(13, 13)));
        checkOutput("back_prev_y", 32'(prev_y), 32'(py(12, 13)));

        // Reverse cell is cheapest but other ways are open
`ifdef GHOST_NO_REVERSE_EN
        revY = 14;
`else
        revY = 12;
`endif
        fillMap(8'd7);
        setCell(16, 12, 1);
        runRound(1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rev_next_x", 32'(next_x), 32'(px(16, 23)));
        checkOutput("rev_next_y", 32'(next_y), 32'(py(revY, 12)));

        // Dead end: only the reverse cell is open
        fillMap(8'd255);
        setCell(16, 12, 1);
        runRound(1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("dead_next_x", 32'(next_x), 32'(px(16, 23)));
        checkOutput("dead_next_y", 32'(next_y), 32'(py(12, 13)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
